// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM states, port indices and
// the all-ones byte-enable pattern.
package sram_arb_pkg;

    typedef enum logic [0:0] {
        ST_ARB = 1'b0,
        ST_RMW = 1'b1
    } arb_state_e;

    localparam int unsigned P0 = 0;
    localparam int unsigned P1 = 1;

    // Sliced to DW/8 bits at the use site.
    localparam logic [63:0] BE_FULL = '1;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way arbiter: round-robin or fixed priority, with a lock window that lets the
// last owner keep the SRAM for at most MAX_HOLD consecutive contended accepts.
module sram_rr_arb2
    import sram_arb_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned MAX_HOLD   = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    input  logic [1:0] accept_i,
    input  logic       enable_i,
    output logic [1:0] gnt_o,
    output logic       owner_o
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    logic          last_q, last_d;
    logic          lock_q, lock_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          window;
    logic          pick;
    logic          acc_port;

    always_comb begin
        window = lock_q & req_i[last_q];
        if (req_i[P0] & req_i[P1]) begin
            if (window) begin
                pick = (hold_q >= HW'(MAX_HOLD)) ? ~last_q : last_q;
            end else if (FIXED_PRIO != 0) begin
                pick = 1'b0;
            end else begin
                pick = ~last_q;
            end
        end else begin
            pick = req_i[P1];
        end
        gnt_o = '0;
        if (enable_i && (req_i != 2'b00)) begin
            gnt_o[pick] = 1'b1;
        end
    end

    // The hold count includes the accept that made a port owner, so a locked port
    // gets exactly MAX_HOLD contended grants before the other side is served.
    always_comb begin
        last_d   = last_q;
        lock_d   = lock_q;
        hold_d   = hold_q;
        acc_port = accept_i[P1];
        if (accept_i != 2'b00) begin
            last_d = acc_port;
            lock_d = lock_i[acc_port];
            if (!req_i[~acc_port]) begin
                hold_d = '0;
            end else if (acc_port != last_q) begin
                hold_d = HW'(1);
            end else if (hold_q != HW'(MAX_HOLD)) begin
                hold_d = hold_q + HW'(1);
            end
        end else if (!req_i[~last_q]) begin
            hold_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
            lock_q <= 1'b0;
            hold_q <= '0;
        end else begin
            last_q <= last_d;
            lock_q <= lock_d;
            hold_q <= hold_d;
        end
    end

    assign owner_o = last_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between two masters; partial-byte writes
// become a read cycle followed by a merged write-back cycle.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned AW         = 10,
    parameter int unsigned DW         = 32,
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned MAX_HOLD   = 8
) (
    input  logic            I_HCLK,
    input  logic            I_HRESETn,
    input  logic            I_REQ0,
    input  logic            I_WR0,
    input  logic [AW-1:0]   I_ADDR0,
    input  logic [DW-1:0]   I_WDATA0,
    input  logic [DW/8-1:0] I_BE0,
    input  logic            I_LOCK0,
    input  logic            I_REQ1,
    input  logic            I_WR1,
    input  logic [AW-1:0]   I_ADDR1,
    input  logic [DW-1:0]   I_WDATA1,
    input  logic [DW/8-1:0] I_BE1,
    input  logic            I_LOCK1,
    output logic            O_GNT0,
    output logic            O_GNT1,
    output logic            O_RVALID0,
    output logic            O_RVALID1,
    output logic [DW-1:0]   O_RDATA,
    output logic [AW-1:0]   O_MADDR,
    output logic [DW-1:0]   O_MWDATA,
    output logic            O_MWREN,
    input  logic [DW-1:0]   I_MRDATA
);

    localparam int unsigned BW = DW / 8;

    arb_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [BW-1:0] be_q, be_d;
    logic          rd_vld_q, rd_vld_d;

    logic [1:0]    req, lock, gnt, accept;
    logic          owner, enable;
    logic          sel_wr, be_full, be_none;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [BW-1:0] sel_be;

    assign req    = {I_REQ1, I_REQ0};
    assign lock   = {I_LOCK1, I_LOCK0};
    assign enable = I_HRESETn & (state_q == ST_ARB);
    assign accept = req & gnt;

    sram_rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO),
        .MAX_HOLD  (MAX_HOLD)
    ) u_arb (
        .clk_i   (I_HCLK),
        .rst_ni  (I_HRESETn),
        .req_i   (req),
        .lock_i  (lock),
        .accept_i(accept),
        .enable_i(enable),
        .gnt_o   (gnt),
        .owner_o (owner)
    );

    always_comb begin
        sel_wr    = gnt[P1] ? I_WR1    : I_WR0;
        sel_addr  = gnt[P1] ? I_ADDR1  : I_ADDR0;
        sel_wdata = gnt[P1] ? I_WDATA1 : I_WDATA0;
        sel_be    = gnt[P1] ? I_BE1    : I_BE0;
        be_full   = (sel_be == BE_FULL[BW-1:0]);
        be_none   = (sel_be == '0);
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rd_vld_d = 1'b0;
        O_MADDR  = '0;
        O_MWDATA = '0;
        O_MWREN  = 1'b0;
        if (state_q == ST_RMW) begin
            O_MADDR = addr_q;
            O_MWREN = 1'b1;
            for (int unsigned b = 0; b < BW; b++) begin
                O_MWDATA[b*8 +: 8] = be_q[b] ? wdata_q[b*8 +: 8] : I_MRDATA[b*8 +: 8];
            end
            state_d = ST_ARB;
        end else if (accept != 2'b00) begin
            if (!sel_wr) begin
                O_MADDR  = sel_addr;
                rd_vld_d = 1'b1;
            end else if (be_full) begin
                O_MADDR  = sel_addr;
                O_MWDATA = sel_wdata;
                O_MWREN  = 1'b1;
            end else if (!be_none) begin
                // Fetch the old word now; the merge happens in the RMW cycle.
                O_MADDR = sel_addr;
                addr_d  = sel_addr;
                wdata_d = sel_wdata;
                be_d    = sel_be;
                state_d = ST_RMW;
            end
        end
        if (!I_HRESETn) begin
            O_MADDR  = '0;
            O_MWDATA = '0;
            O_MWREN  = 1'b0;
        end
    end

    always_ff @(posedge I_HCLK) begin
        if (!I_HRESETn) begin
            state_q  <= ST_ARB;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    // A read accept always makes its port the owner, so the owner one cycle later
    // tells which port the returning data belongs to.
    assign O_GNT0    = gnt[P0];
    assign O_GNT1    = gnt[P1];
    assign O_RVALID0 = rd_vld_q & ~owner;
    assign O_RVALID1 = rd_vld_q & owner;
    assign O_RDATA   = I_MRDATA;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed sequences, a write/readback vector table and
// a randomized run against a transaction-level model of arbitration and memory.
module tb_sram_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MH = 8;

    logic clk = 1'b0;
    logic rstn;
    logic load;
    always #5 clk = ~clk;

    logic          req[2], wr[2], lock[2];
    logic [AW-1:0] addr[2];
    logic [DW-1:0] wd[2];
    logic [3:0]    be[2];

    logic          g0_r, g1_r, rv0_r, rv1_r, mwren_r;
    logic [DW-1:0] rdata_r, mwdata_r, mrdata_r;
    logic [AW-1:0] maddr_r;
    logic          g0_f, g1_f, rv0_f, rv1_f, mwren_f;
    logic [DW-1:0] rdata_f, mwdata_f, mrdata_f;
    logic [AW-1:0] maddr_f;

    logic [DW-1:0] mem_r[16];
    logic [DW-1:0] mem_f[16];

    int checks = 0;
    int errors = 0;

    sram_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(0), .MAX_HOLD(MH)) dut_rr (
        .I_HCLK(clk), .I_HRESETn(rstn),
        .I_REQ0(req[0]), .I_WR0(wr[0]), .I_ADDR0(addr[0]), .I_WDATA0(wd[0]),
        .I_BE0(be[0]), .I_LOCK0(lock[0]),
        .I_REQ1(req[1]), .I_WR1(wr[1]), .I_ADDR1(addr[1]), .I_WDATA1(wd[1]),
        .I_BE1(be[1]), .I_LOCK1(lock[1]),
        .O_GNT0(g0_r), .O_GNT1(g1_r), .O_RVALID0(rv0_r), .O_RVALID1(rv1_r),
        .O_RDATA(rdata_r), .O_MADDR(maddr_r), .O_MWDATA(mwdata_r), .O_MWREN(mwren_r),
        .I_MRDATA(mrdata_r)
    );

    sram_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1), .MAX_HOLD(MH)) dut_fp (
        .I_HCLK(clk), .I_HRESETn(rstn),
        .I_REQ0(req[0]), .I_WR0(wr[0]), .I_ADDR0(addr[0]), .I_WDATA0(wd[0]),
        .I_BE0(be[0]), .I_LOCK0(lock[0]),
        .I_REQ1(req[1]), .I_WR1(wr[1]), .I_ADDR1(addr[1]), .I_WDATA1(wd[1]),
        .I_BE1(be[1]), .I_LOCK1(lock[1]),
        .O_GNT0(g0_f), .O_GNT1(g1_f), .O_RVALID0(rv0_f), .O_RVALID1(rv1_f),
        .O_RDATA(rdata_f), .O_MADDR(maddr_f), .O_MWDATA(mwdata_f), .O_MWREN(mwren_f),
        .I_MRDATA(mrdata_f)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'h11223344;
        return {i[7:0], 8'hA5, 8'(3 * i), 8'h5A};
    endfunction

    // Synchronous SRAM models, one per DUT; read data appears one cycle after the address.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 16; i++) begin
                mem_r[i] <= init_word(i);
                mem_f[i] <= init_word(i);
            end
        end else begin
            if (mwren_r) mem_r[maddr_r[3:0]] <= mwdata_r;
            if (mwren_f) mem_f[maddr_f[3:0]] <= mwdata_f;
        end
        mrdata_r <= mem_r[maddr_r[3:0]];
        mrdata_f <= mem_f[maddr_f[3:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int p, input logic r, input logic w, input int a,
                           input logic [31:0] d, input logic [3:0] b, input logic l);
        req[p] = r; wr[p] = w; addr[p] = AW'(a); wd[p] = d; be[p] = b; lock[p] = l;
    endtask

    typedef struct {
        int          a;
        logic [3:0]  b;
        logic [31:0] d;
        logic        exp_rmw;
        logic        exp_wren;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[6];
    int   exp_seq[$];

    // Reference model state for the randomized run.
    logic [31:0] ref_mem[16];
    int          last, last_lock, run, exp_g, pend_port, p;
    bit          in_rmw, in_rmw_next, exp_wren;
    logic [31:0] pend_data;
    logic [1:0]  exp_gv, exp_rv;

    initial begin
        vecs[0] = '{5, 4'b0010, 32'hAABBCCDD, 1'b1, 1'b0, 32'h1122CC44};
        vecs[1] = '{5, 4'b1111, 32'h01020304, 1'b0, 1'b1, 32'h01020304};
        vecs[2] = '{5, 4'b0000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h01020304};
        vecs[3] = '{5, 4'b1001, 32'hA0B0C0D0, 1'b1, 1'b0, 32'hA00203D0};
        vecs[4] = '{6, 4'b0100, 32'h00EE0000, 1'b1, 1'b0, 32'h06EE125A};
        vecs[5] = '{6, 4'b1110, 32'h12345678, 1'b1, 1'b0, 32'h1234565A};

        // Reset held with both ports requesting.
        rstn = 1'b0;
        load = 1'b1;
        set_cmd(0, 1, 0, 1, 0, 4'hF, 0);
        set_cmd(1, 1, 0, 2, 0, 4'hF, 0);
        @(negedge clk);
        chk("rst_gnt", {g1_r, g0_r}, 2'b00);
        chk("rst_mwren", mwren_r, 1'b0);
        chk("rst_rvalid", {rv1_r, rv0_r}, 2'b00);
        chk("rst_maddr", maddr_r, '0);
        tick();
        load = 1'b0;
        tick();
        rstn = 1'b1;

        // Both ports reading: grants alternate starting with port 0.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_gnt", {g1_r, g0_r}, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k > 0) begin
                chk("rr_rvalid", {rv1_r, rv0_r}, (k % 2 == 1) ? 2'b01 : 2'b10);
                chk("rr_rdata", rdata_r, init_word((k % 2 == 1) ? 1 : 2));
            end
            tick();
        end
        req[0] = 1'b0;
        req[1] = 1'b0;
        @(negedge clk);
        chk("rr_rvalid_last", {rv1_r, rv0_r}, 2'b10);
        chk("rr_rdata_last", rdata_r, init_word(2));
        tick();

        // Write/readback vectors on port 0.
        foreach (vecs[i]) begin
            set_cmd(0, 1, 1, vecs[i].a, vecs[i].d, vecs[i].b, 0);
            @(negedge clk);
            chk("vec_wr_gnt", g0_r, 1'b1);
            chk("vec_wr_wren", mwren_r, vecs[i].exp_wren);
            if (vecs[i].exp_wren) chk("vec_wr_data", mwdata_r, vecs[i].d);
            tick();
            set_cmd(0, 1, 0, vecs[i].a, 0, 4'hF, 0);
            if (vecs[i].exp_rmw) begin
                @(negedge clk);
                chk("vec_rmw_gnt", {g1_r, g0_r}, 2'b00);
                chk("vec_rmw_wren", mwren_r, 1'b1);
                chk("vec_rmw_addr", maddr_r, AW'(vecs[i].a));
                chk("vec_rmw_data", mwdata_r, vecs[i].exp_rd);
                tick();
            end
            @(negedge clk);
            chk("vec_rd_gnt", g0_r, 1'b1);
            chk("vec_rd_wren", mwren_r, 1'b0);
            tick();
            req[0] = 1'b0;
            @(negedge clk);
            chk("vec_rd_valid", rv0_r, 1'b1);
            chk("vec_rd_data", rdata_r, vecs[i].exp_rd);
            tick();
        end

        // Port 1 locked: MH grants to port 1, then one to port 0, repeating.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        set_cmd(0, 1, 0, 1, 0, 4'hF, 0);
        set_cmd(1, 1, 0, 2, 0, 4'hF, 1);
        exp_seq.push_back(0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < MH; i++) exp_seq.push_back(1);
            exp_seq.push_back(0);
        end
        foreach (exp_seq[i]) begin
            @(negedge clk);
            chk("lock_gnt", {g1_r, g0_r}, (exp_seq[i] == 1) ? 2'b10 : 2'b01);
            tick();
        end
        req[0] = 1'b0;
        req[1] = 1'b0;
        lock[1] = 1'b0;

        // Fixed priority instance.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        set_cmd(0, 1, 0, 1, 0, 4'hF, 0);
        set_cmd(1, 1, 0, 2, 0, 4'hF, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("fp_gnt", {g1_f, g0_f}, 2'b01);
            if (k > 0) begin
                chk("fp_rvalid", {rv1_f, rv0_f}, 2'b01);
                chk("fp_rdata", rdata_f, init_word(1));
            end
            tick();
        end
        req[0] = 1'b0;
        @(negedge clk);
        chk("fp_gnt_p1", {g1_f, g0_f}, 2'b10);
        tick();
        req[1] = 1'b0;
        set_cmd(0, 1, 1, 3, 32'hDEADBEEF, 4'b0000, 0);
        @(negedge clk);
        chk("fp_be0_gnt", g0_f, 1'b1);
        chk("fp_be0_wren", mwren_f, 1'b0);
        tick();
        req[0] = 1'b0;
        @(negedge clk);
        chk("fp_be0_wren_next", mwren_f, 1'b0);
        tick();

        // Reset during the RMW write-back cycle drops the write.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        set_cmd(0, 1, 1, 3, 32'h000000FF, 4'b0001, 0);
        @(negedge clk);
        chk("rstrmw_gnt", g0_r, 1'b1);
        chk("rstrmw_wren_acc", mwren_r, 1'b0);
        tick();
        rstn = 1'b0;
        req[0] = 1'b0;
        @(negedge clk);
        chk("rstrmw_wren", mwren_r, 1'b0);
        chk("rstrmw_gnt0", {g1_r, g0_r}, 2'b00);
        tick();
        rstn = 1'b1;
        set_cmd(0, 1, 0, 3, 0, 4'hF, 0);
        set_cmd(1, 1, 0, 4, 0, 4'hF, 0);
        @(negedge clk);
        chk("rstrmw_first", {g1_r, g0_r}, 2'b01);
        tick();
        req[0] = 1'b0;
        req[1] = 1'b0;
        @(negedge clk);
        chk("rstrmw_rvalid", rv0_r, 1'b1);
        chk("rstrmw_mem", rdata_r, init_word(3));
        tick();

        // Randomized run on the round-robin instance against the reference model.
        rstn = 1'b0;
        load = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        tick();
        load = 1'b0;
        rstn = 1'b1;
        last = 1; last_lock = 0; run = 0; in_rmw = 0; pend_port = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            exp_g = -1;
            if (!in_rmw) begin
                if (req[0] && req[1]) begin
                    if (last_lock != 0) exp_g = (run >= MH) ? 1 - last : last;
                    else exp_g = 1 - last;
                end else if (req[0]) begin
                    exp_g = 0;
                end else if (req[1]) begin
                    exp_g = 1;
                end
            end
            exp_gv = (exp_g < 0) ? 2'b00 : ((exp_g == 0) ? 2'b01 : 2'b10);
            chk("rand_gnt", {g1_r, g0_r}, exp_gv);
            exp_wren = in_rmw || (exp_g >= 0 && wr[exp_g] && be[exp_g] == 4'hF);
            chk("rand_wren", mwren_r, exp_wren);
            exp_rv = (pend_port < 0) ? 2'b00 : ((pend_port == 0) ? 2'b01 : 2'b10);
            chk("rand_rvalid", {rv1_r, rv0_r}, exp_rv);
            if (pend_port >= 0) chk("rand_rdata", rdata_r, pend_data);

            pend_port = -1;
            in_rmw_next = 0;
            if (exp_g >= 0) begin
                p = exp_g;
                if (!wr[p]) begin
                    pend_port = p;
                    pend_data = ref_mem[addr[p][3:0]];
                end else if (be[p] != 4'h0) begin
                    for (int b = 0; b < 4; b++)
                        if (be[p][b]) ref_mem[addr[p][3:0]][8*b +: 8] = wd[p][8*b +: 8];
                    if (be[p] != 4'hF) in_rmw_next = 1;
                end
                if (req[1 - p]) run = (p == last) ? run + 1 : 1;
                else run = 0;
                last = p;
                last_lock = int'(lock[p]);
            end else if (!req[1 - last]) begin
                run = 0;
            end
            in_rmw = in_rmw_next;

            tick();
            for (int q = 0; q < 2; q++) begin
                if (exp_g == q || !req[q]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        req[q]  = 1'b1;
                        wr[q]   = 1'($urandom_range(0, 1));
                        addr[q] = AW'($urandom_range(0, 7));
                        wd[q]   = $urandom;
                        case ($urandom_range(0, 3))
                            0:       be[q] = 4'h0;
                            1:       be[q] = 4'hF;
                            default: be[q] = 4'($urandom_range(0, 15));
                        endcase
                        lock[q] = (q == 1) ? ($urandom_range(0, 3) != 0)
                                           : ($urandom_range(0, 4) == 0);
                    end else begin
                        req[q] = 1'b0;
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
